// File: rtl/adc_capture_fsmc_reader_if.sv
// rtl/adc_capture_fsmc_reader_if.sv - FSMC read-side bus between the MCU and the ADC capture engine
interface adc_capture_fsmc_reader_if;
  logic        FPGA_OE;
  logic [15:0] FSMC_D;

  modport master (output FPGA_OE, input FSMC_D);
  modport slave  (input FPGA_OE, output FSMC_D);
endinterface

// File: rtl/adc_capture_fsmc_reader.sv
// rtl/adc_capture_fsmc_reader.sv - delayed ADC capture into RAM with FSMC strobe readout
// Optional ADC_TEST_PATTERN_EN: store a wr_addr ramp instead of adc_data.
module adc_capture_fsmc_reader #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 5000,
  parameter int ADDR_W       = 13,
  parameter int DELAY_CYCLES = 6400000,
  parameter int DELAY_W      = 24,
  parameter int DECIM        = 1,
  parameter int ACK_DELAY    = 1
) (
  input  logic                        clk_80mhz,
  input  logic                        pll_locked,
  input  logic                        START_FPGA,
  input  logic [DATA_W-1:0]           adc_data,
  adc_capture_fsmc_reader_if.slave    fsmc,
  output logic                        busy,
  output logic                        capture_done,
  output logic                        overrun
);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ACK_W = $clog2(ACK_DELAY + 1);

  typedef enum logic [2:0] {IDLE, DELAY, CAPTURE, READY, READOUT} state_t;

  state_t             state;
  logic               start_meta, start_sync, start_prev;
  logic               oe_meta, oe_sync, oe_prev;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DEC_W-1:0]   dec_cnt;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_idx;
  logic [ACK_W-1:0]   ack_cnt;
  logic               word_pending;
  logic [15:0]        fsmc_d;
  logic [DATA_W-1:0]  buffer [DEPTH];
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  wr_data;

  wire start_pulse = start_sync & ~start_prev;
  wire oe_fall     = ~oe_sync & oe_prev;
  wire oe_rise     = oe_sync & ~oe_prev;
  wire wr_en       = (state == CAPTURE) && (dec_cnt == '0);
  wire last_word   = (rd_idx == ADDR_W'(DEPTH - 1));

`ifdef ADC_TEST_PATTERN_EN
  assign wr_data = DATA_W'(wr_addr);
`else
  assign wr_data = adc_data;
`endif

  assign fsmc.FSMC_D = fsmc_d;

  // Sample RAM: no reset, read is registered and settles well before the ack countdown ends.
  always_ff @(posedge clk_80mhz) begin
    if (wr_en) buffer[wr_addr] <= wr_data;
    rd_data <= buffer[rd_idx];
  end

  always_ff @(posedge clk_80mhz or negedge pll_locked) begin
    if (!pll_locked) begin
      state        <= IDLE;
      start_meta   <= 1'b0;
      start_sync   <= 1'b0;
      start_prev   <= 1'b0;
      oe_meta      <= 1'b1;
      oe_sync      <= 1'b1;
      oe_prev      <= 1'b1;
      delay_cnt    <= '0;
      dec_cnt      <= '0;
      wr_addr      <= '0;
      rd_idx       <= '0;
      ack_cnt      <= '0;
      word_pending <= 1'b0;
      fsmc_d       <= 16'h0000;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      start_meta <= START_FPGA;
      start_sync <= start_meta;
      start_prev <= start_sync;
      oe_meta    <= fsmc.FPGA_OE;
      oe_sync    <= oe_meta;
      oe_prev    <= oe_sync;

      if (start_pulse && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          fsmc_d <= 16'h0000;
          if (start_pulse) begin
            state     <= DELAY;
            delay_cnt <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        DELAY: begin
          if (delay_cnt == DELAY_W'(DELAY_CYCLES - 1)) begin
            state   <= CAPTURE;
            wr_addr <= '0;
            dec_cnt <= '0;
          end else begin
            delay_cnt <= delay_cnt + DELAY_W'(1);
          end
        end
        CAPTURE: begin
          dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);
          if (wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (wr_addr == ADDR_W'(DEPTH - 1)) begin
              state        <= READY;
              busy         <= 1'b0;
              capture_done <= 1'b1;
              fsmc_d       <= 16'h8000;
            end
          end
        end
        READY: begin
          fsmc_d <= 16'h8000;
          if (oe_fall) begin
            state        <= READOUT;
            rd_idx       <= '0;
            ack_cnt      <= ACK_W'(ACK_DELAY);
            word_pending <= 1'b1;
            fsmc_d       <= 16'h0000;
          end
        end
        READOUT: begin
          if (oe_fall) begin
            fsmc_d       <= 16'h0000;
            ack_cnt      <= ACK_W'(ACK_DELAY);
            word_pending <= 1'b1;
          end else if (oe_rise) begin
            // A strobe released before its word appeared still consumes that word.
            fsmc_d       <= 16'h0000;
            word_pending <= 1'b0;
            if (last_word) begin
              state        <= IDLE;
              capture_done <= 1'b0;
              rd_idx       <= '0;
            end else begin
              rd_idx <= rd_idx + ADDR_W'(1);
            end
          end else if (word_pending) begin
            if (ack_cnt > ACK_W'(1)) begin
              ack_cnt <= ack_cnt - ACK_W'(1);
            end else begin
              ack_cnt      <= '0;
              word_pending <= 1'b0;
              fsmc_d       <= {1'b0, 1'b1, last_word, 13'(rd_data)};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture_fsmc_reader.sv
// tb/tb_adc_capture_fsmc_reader.sv - scoreboard bench for adc_capture_fsmc_reader
module tb_adc_capture_fsmc_reader;
  localparam int DEPTH = 8;
  localparam int DLY   = 20;
`ifdef ADC_TEST_PATTERN_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk_80mhz = 1'b0;
  logic        pll_locked = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        busy1, cd1, ov1, busy3, cd3, ov3;
  logic        sel = 1'b0;

  int errors = 0;
  int checks = 0;
  int tick = 0;
  int ref_tick = 0;
  int adc_base = 0;
  logic [15:0] exp_q[$];

  adc_capture_fsmc_reader_if bus1();
  adc_capture_fsmc_reader_if bus3();

  adc_capture_fsmc_reader #(.DATA_W(12), .DEPTH(DEPTH), .ADDR_W(3), .DELAY_CYCLES(DLY),
    .DELAY_W(24), .DECIM(1), .ACK_DELAY(1)) dut1 (
    .clk_80mhz(clk_80mhz), .pll_locked(pll_locked), .START_FPGA(start1), .adc_data(adc_data),
    .fsmc(bus1.slave), .busy(busy1), .capture_done(cd1), .overrun(ov1));

  adc_capture_fsmc_reader #(.DATA_W(12), .DEPTH(DEPTH), .ADDR_W(3), .DELAY_CYCLES(DLY),
    .DELAY_W(24), .DECIM(3), .ACK_DELAY(1)) dut3 (
    .clk_80mhz(clk_80mhz), .pll_locked(pll_locked), .START_FPGA(start3), .adc_data(adc_data),
    .fsmc(bus3.slave), .busy(busy3), .capture_done(cd3), .overrun(ov3));

  wire [15:0] d_m    = sel ? bus3.FSMC_D : bus1.FSMC_D;
  wire        busy_m = sel ? busy3 : busy1;
  wire        cd_m   = sel ? cd3 : cd1;
  wire        ov_m   = sel ? ov3 : ov1;

  initial forever #5 clk_80mhz = ~clk_80mhz;

  // ADC model: value presented at a capture edge is adc_base + cycles since ref_tick.
  initial forever begin
    @(posedge clk_80mhz);
    #1;
    tick++;
    adc_data = 12'(adc_base + tick - ref_tick);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start3 = v; else start1 = v;
  endtask

  task automatic set_oe(input logic v);
    if (sel) bus3.FPGA_OE = v; else bus1.FPGA_OE = v;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_80mhz);
  endtask

  task automatic capture(input int decim, input int base, input int poke);
    int lat;
    int c;
    lat = 0;
    @(posedge clk_80mhz);
    #2;
    set_start(1'b1);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk_80mhz);
      @(negedge clk_80mhz);
      if (busy_m) lat = i;
    end
    check("busy_latency", lat, 3);
    check("overrun_cleared", ov_m, 0);
    ref_tick = tick + DLY;
    adc_base = base;
    set_start(1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      logic [11:0] v;
      v = RAMP ? 12'(k) : 12'(base + decim * k);
      exp_q.push_back(16'h4000 | ((k == DEPTH - 1) ? 16'h2000 : 16'h0000) | {4'h0, v});
    end
    c = DLY + 1 + (DEPTH - 1) * decim;
    for (int j = 1; j <= c; j++) begin
      @(negedge clk_80mhz);
      if (j == poke) set_start(1'b1);
      if (j == poke + 4) set_start(1'b0);
      if (j == DLY) check("busy_in_delay", {busy_m, cd_m}, 2'b10);
      if (j == c - 1) check("not_done_early", cd_m, 0);
    end
    check("ready_flags", {busy_m, cd_m}, 2'b01);
    check("ready_word", d_m, 16'h8000);
  endtask

  task automatic readout(input int poke_word, input int abort_word, input logic exp_ov);
    logic [15:0] e;
    for (int w = 0; w < DEPTH; w++) begin
      set_oe(1'b0);
      cycles(6);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check($sformatf("word%0d", w), d_m, e);
      if (w == abort_word) begin
        pll_locked = 1'b0;
        #1;
        check("async_reset_outputs", {busy_m, cd_m, ov_m, d_m}, 0);
        exp_q.delete();
        set_oe(1'b1);
        cycles(3);
        pll_locked = 1'b1;
        cycles(3);
        return;
      end
      if (w == poke_word) set_start(1'b1);
      set_oe(1'b1);
      cycles(6);
      if (w == poke_word) set_start(1'b0);
      check($sformatf("word%0d_release", w), d_m, 0);
    end
    check("idle_after_readout", {busy_m, cd_m, ov_m, d_m}, {2'b00, exp_ov, 16'h0000});
  endtask

  initial begin
    bus1.FPGA_OE = 1'b1;
    bus3.FPGA_OE = 1'b1;
    cycles(4);
    check("in_reset", {busy1, cd1, ov1, bus1.FSMC_D}, 0);
    pll_locked = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_80mhz);
      if (i % 10 == 9) check("idle_quiet", {busy1, cd1, ov1, bus1.FSMC_D}, 0);
    end

    sel = 1'b0;
    capture(1, 'h100, 0);
    readout(-1, -1, 1'b0);

    sel = 1'b1;
    capture(3, 0, 0);
    readout(-1, -1, 1'b0);

    sel = 1'b0;
    capture(1, 'h3A0, 19);
    check("overrun_capture", ov1, 1);
    readout(3, -1, 1'b1);
    capture(1, 'h7F0, 0);
    readout(-1, 4, 1'b0);
    check("post_reset_idle", {busy1, cd1, ov1, bus1.FSMC_D}, 0);

    capture(1, 'hFFF, 0);
    readout(-1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
